piso_stream: RTL and testbench
==============================

Name: piso_stream

Overview:
Parametrised parallel-in/serial-out buffer, successor to the addressed-readout PISO used on the AES datapath.
- Captures N_REG words of R_DATA_WIDTH on a load strobe.
- Streams the words out one per accepted beat under a valid/ready handshake, with word-order select and a last-word flag.
- Sits between wide result registers (AES state/key, hash digest) and the 32-bit bus-side interface.

Parameters:
R_DATA_WIDTH, 32, width of one output word
N_REG, 8, number of words in the parallel input
N_REG_BITS, (N_REG==1)?1:$clog2(N_REG), index/counter width (derived, not overridden)
MSW_FIRST, 0, 0 = word 0 (din[R_DATA_WIDTH-1:0]) sent first; 1 = word N_REG-1 sent first

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
load  in  1  capture din into buffer; honoured only when busy=0
din  in  R_DATA_WIDTH*N_REG  parallel input words
busy  out  1  high from cycle after accepted load until final beat accepted
dout  out  R_DATA_WIDTH  current serial word; 0 whenever dout_valid=0
dout_valid  out  1  dout holds a valid word
dout_ready  in  1  consumer accepts dout this cycle
dout_last  out  1  high with the final word of a burst
read  in  1  addressed read strobe (only with PISO_ADDR_READ_EN)
addr  in  N_REG_BITS  addressed read index (only with PISO_ADDR_READ_EN)

Behaviour:
- Reset (synchronous, active-high, clk edge): state=IDLE, cnt=0, buffer=0; busy=0, dout=0, dout_valid=0, dout_last=0. Reset mid-burst aborts immediately; no partial words after reset.
- States: IDLE, SEND.
- IDLE:
  - load=1 -> buffer<=din, cnt<=0, state<=SEND.
  - Next cycle: busy=1, dout_valid=1, dout=first word. Load-to-first-word latency is 1 cycle.
  - dout_last=1 on the first word if N_REG==1.
- SEND:
  - Word index = cnt (MSW_FIRST=0) or N_REG-1-cnt (MSW_FIRST=1).
  - dout_valid&&dout_ready with cnt<N_REG-1 -> cnt+1; next word is presented the following cycle. Back-to-back acceptance gives 1 word/cycle.
  - dout_valid&&!dout_ready -> dout, dout_valid and dout_last held stable.
  - dout_last=1 exactly when cnt==N_REG-1.
  - Handshake on the last word -> state<=IDLE, cnt<=0; next cycle busy=0, dout_valid=0, dout=0, dout_last=0.
- load while busy=1 is ignored, including the cycle of the final handshake; the buffer is never overwritten mid-burst.
- din changes after capture have no effect on the burst.
- Burst length is always N_REG beats; cnt never wraps past N_REG-1.
- All outputs are registered; no combinational path from any input to any output.

Optional Feature:
Macro PISO_ADDR_READ_EN.
- Defined:
  - read and addr ports exist.
  - In IDLE, read=1 -> next cycle dout = buffer word addr (absolute index, MSW_FIRST ignored); dout_valid stays 0.
  - read=0 in IDLE -> dout=0.
  - addr>=N_REG returns 0.
  - read is ignored while busy=1 or when coincident with load (load wins).
- Undefined: read/addr ports absent; dout is 0 in IDLE.

Decomposition:
- Shared header piso_defs.vh: state encodings PISO_ST_IDLE=1'b0, PISO_ST_SEND=1'b1, and the N_REG_BITS derivation expression, reused by other PISO-family blocks.
- One sub-module, piso_word_sel: combinational indexed part-select of a word from the buffer (index, MSW_FIRST reversal, out-of-range->0). Used by both the stream path and the addressed-read path.
- Top holds the FSM, counter and output registers.

Test Plan:
- R_DATA_WIDTH=32, N_REG=4, MSW_FIRST=0, din=0x44444444_33333333_22222222_11111111, load 1 cycle, dout_ready=1 -> dout 0x11111111, 0x22222222, 0x33333333, 0x44444444 on 4 consecutive cycles starting 1 cycle after load; dout_last only on 0x44444444; busy falls next cycle.
- Same with MSW_FIRST=1 -> order 0x44444444 down to 0x11111111.
- dout_ready toggling 1,0,0,1,… -> each word held while stalled; no words lost or duplicated; 4 accepted beats total.
- load=1 pulsed mid-burst with a new din -> ignored; original words still streamed; a load 1 cycle after busy=0 starts a new burst.
- rst asserted during beat 2 -> next cycle all outputs 0, state IDLE; a subsequent load streams from word 0.
- N_REG=1 -> single beat with dout_valid and dout_last together. With PISO_ADDR_READ_EN: read=1, addr=2 in IDLE after the first load -> dout=0x33333333 and dout_valid=0 one cycle later.

Source files
------------

// File: rtl/piso_stream_pkg.sv
// piso_stream_pkg
//   Shared definitions for the PISO family: FSM state encodings and the
//   index-width derivation used by every block that carries a word index.
//   No ports (package).
package piso_stream_pkg;

  typedef enum logic {
    PISO_ST_IDLE = 1'b0,
    PISO_ST_SEND = 1'b1
  } piso_state_t;

  // Index/counter width for n words; a single-word buffer still gets one bit
  // so that the counter and addr ports never collapse to zero width.
  function automatic int piso_idx_bits(input int n);
    return (n == 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/piso_stream_if.sv
// piso_stream_if
//   Bundles the load/parallel-input side and the serial valid/ready side of a
//   piso_stream instance.
//   Parameters: R_DATA_WIDTH (word width), N_REG (words per burst).
//   Signals: load, din, busy, dout, dout_valid, dout_ready, dout_last,
//            plus read/addr when PISO_ADDR_READ_EN is defined.
//   Modports: master = the PISO itself, slave = the producer/consumer side.
interface piso_stream_if #(
  parameter int R_DATA_WIDTH = 32,
  parameter int N_REG        = 8
) ();
  localparam int N_REG_BITS = piso_stream_pkg::piso_idx_bits(N_REG);

  logic                            load;
  logic [R_DATA_WIDTH*N_REG-1:0]   din;
  logic                            busy;
  logic [R_DATA_WIDTH-1:0]         dout;
  logic                            dout_valid;
  logic                            dout_ready;
  logic                            dout_last;
`ifdef PISO_ADDR_READ_EN
  logic                            read;
  logic [N_REG_BITS-1:0]           addr;

  modport master (
    input  load, din, dout_ready, read, addr,
    output busy, dout, dout_valid, dout_last
  );
  modport slave (
    output load, din, dout_ready, read, addr,
    input  busy, dout, dout_valid, dout_last
  );
`else
  modport master (
    input  load, din, dout_ready,
    output busy, dout, dout_valid, dout_last
  );
  modport slave (
    output load, din, dout_ready,
    input  busy, dout, dout_valid, dout_last
  );
`endif

endinterface

// File: rtl/piso_word_sel.sv
// piso_word_sel
//   Combinational word picker: returns word idx of a packed buffer, with
//   optional order reversal (MSW_FIRST) and 0 for any idx >= N_REG.
//   Ports: buffer (R_DATA_WIDTH*N_REG packed words, word 0 in the LSBs),
//          idx (N_REG_BITS), word (R_DATA_WIDTH).
module piso_word_sel #(
  parameter int R_DATA_WIDTH = 32,
  parameter int N_REG        = 8,
  parameter int MSW_FIRST    = 0,
  localparam int N_REG_BITS  = piso_stream_pkg::piso_idx_bits(N_REG)
) (
  input  logic [R_DATA_WIDTH*N_REG-1:0] buffer,
  input  logic [N_REG_BITS-1:0]         idx,
  output logic [R_DATA_WIDTH-1:0]       word
);

  logic [R_DATA_WIDTH-1:0] words [N_REG];

  generate
    for (genvar gi = 0; gi < N_REG; gi++) begin : g_split
      assign words[gi] = buffer[gi*R_DATA_WIDTH +: R_DATA_WIDTH];
    end
  endgenerate

  // Matching only the legal index values makes out-of-range indices fall
  // through to the zero default without a separate range comparison.
  always_comb begin
    word = '0;
    for (int i = 0; i < N_REG; i++) begin
      if (idx == N_REG_BITS'(i)) begin
        word = words[(MSW_FIRST != 0) ? (N_REG - 1 - i) : i];
      end
    end
  end

endmodule

// File: rtl/piso_stream.sv
// piso_stream
//   Parallel-in/serial-out buffer. A load in IDLE captures N_REG words; the
//   words then stream out one per accepted valid/ready beat, dout_last marking
//   the final word. All outputs are registered.
//   Parameters: R_DATA_WIDTH, N_REG, MSW_FIRST (0: word 0 first, 1: word
//   N_REG-1 first).
//   Ports: clk, rst (synchronous, active high), bus (piso_stream_if.master).
//   Optional: define PISO_ADDR_READ_EN to enable read/addr addressed readout
//   of the buffer while IDLE (dout_valid stays low for those reads).
module piso_stream
  import piso_stream_pkg::*;
#(
  parameter int R_DATA_WIDTH = 32,
  parameter int N_REG        = 8,
  parameter int MSW_FIRST    = 0
) (
  input  logic           clk,
  input  logic           rst,
  piso_stream_if.master  bus
);

  localparam int N_REG_BITS = piso_idx_bits(N_REG);
  localparam logic [N_REG_BITS-1:0] LAST_IDX = N_REG_BITS'(N_REG - 1);

  piso_state_t                   state_reg, state_next;
  logic [N_REG_BITS-1:0]         cnt_reg, cnt_next;
  logic [R_DATA_WIDTH*N_REG-1:0] buf_reg, buf_next;
  logic [R_DATA_WIDTH-1:0]       dout_reg, dout_next;
  logic                          dout_valid_reg, dout_valid_next;
  logic                          dout_last_reg, dout_last_next;

  logic                          accept;
  logic [R_DATA_WIDTH-1:0]       stream_word;
  logic [R_DATA_WIDTH-1:0]       idle_word;

  assign accept = dout_valid_reg && bus.dout_ready;

  // State register (also holds counter, buffer and output registers)
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= PISO_ST_IDLE;
      cnt_reg        <= '0;
      buf_reg        <= '0;
      dout_reg       <= '0;
      dout_valid_reg <= 1'b0;
      dout_last_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      buf_reg        <= buf_next;
      dout_reg       <= dout_next;
      dout_valid_reg <= dout_valid_next;
      dout_last_reg  <= dout_last_next;
    end
  end

  // Next-state logic. load is only looked at in IDLE, so a load on the
  // final-handshake cycle is dropped rather than restarting the burst.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    buf_next   = buf_reg;
    unique case (state_reg)
      PISO_ST_IDLE: begin
        if (bus.load) begin
          buf_next   = bus.din;
          cnt_next   = '0;
          state_next = PISO_ST_SEND;
        end
      end
      PISO_ST_SEND: begin
        if (accept) begin
          if (cnt_reg == LAST_IDX) begin
            cnt_next   = '0;
            state_next = PISO_ST_IDLE;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end
      default: state_next = PISO_ST_IDLE;
    endcase
  end

  // The stream word is taken from the *next* buffer/counter so the first
  // word appears in the cycle right after load, and a stalled beat simply
  // re-registers the same word.
  piso_word_sel #(
    .R_DATA_WIDTH (R_DATA_WIDTH),
    .N_REG        (N_REG),
    .MSW_FIRST    (MSW_FIRST)
  ) u_stream_sel (
    .buffer (buf_next),
    .idx    (cnt_next),
    .word   (stream_word)
  );

`ifdef PISO_ADDR_READ_EN
  logic [R_DATA_WIDTH-1:0] rd_word;

  // Addressed reads use absolute word numbering regardless of MSW_FIRST.
  piso_word_sel #(
    .R_DATA_WIDTH (R_DATA_WIDTH),
    .N_REG        (N_REG),
    .MSW_FIRST    (0)
  ) u_read_sel (
    .buffer (buf_reg),
    .idx    (bus.addr),
    .word   (rd_word)
  );

  // A coincident load takes priority over read.
  assign idle_word = (state_reg == PISO_ST_IDLE && bus.read && !bus.load)
                     ? rd_word : '0;
`else
  assign idle_word = '0;
`endif

  // Output logic (feeds the output registers)
  always_comb begin
    dout_valid_next = (state_next == PISO_ST_SEND);
    dout_last_next  = dout_valid_next && (cnt_next == LAST_IDX);
    dout_next       = dout_valid_next ? stream_word : idle_word;
  end

  assign bus.busy       = (state_reg == PISO_ST_SEND);
  assign bus.dout       = dout_reg;
  assign bus.dout_valid = dout_valid_reg;
  assign bus.dout_last  = dout_last_reg;

endmodule

// File: tb/tb_piso_stream.sv
// tb_piso_stream
//   Scoreboard bench for piso_stream. Three instances share clk/rst:
//   0: N_REG=4, MSW_FIRST=0   1: N_REG=4, MSW_FIRST=1   2: N_REG=1.
//   Stimulus pushes expected {last, word} beats into a per-instance queue;
//   a negedge monitor pops and compares on every accepted beat and checks
//   that dout/dout_last are at their idle value whenever dout_valid is low.
//   Addressed-read test runs only when PISO_ADDR_READ_EN is defined.
module tb_piso_stream;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  piso_stream_if #(.R_DATA_WIDTH(32), .N_REG(4)) if0 ();
  piso_stream_if #(.R_DATA_WIDTH(32), .N_REG(4)) if1 ();
  piso_stream_if #(.R_DATA_WIDTH(32), .N_REG(1)) if2 ();

  piso_stream #(.R_DATA_WIDTH(32), .N_REG(4), .MSW_FIRST(0)) dut0 (
    .clk (clk), .rst (rst), .bus (if0));
  piso_stream #(.R_DATA_WIDTH(32), .N_REG(4), .MSW_FIRST(1)) dut1 (
    .clk (clk), .rst (rst), .bus (if1));
  piso_stream #(.R_DATA_WIDTH(32), .N_REG(1), .MSW_FIRST(0)) dut2 (
    .clk (clk), .rst (rst), .bus (if2));

  logic        vld [3];
  logic        rdy [3];
  logic        lst [3];
  logic        bsy [3];
  logic [31:0] dat [3];
  assign vld[0] = if0.dout_valid; assign vld[1] = if1.dout_valid; assign vld[2] = if2.dout_valid;
  assign rdy[0] = if0.dout_ready; assign rdy[1] = if1.dout_ready; assign rdy[2] = if2.dout_ready;
  assign lst[0] = if0.dout_last;  assign lst[1] = if1.dout_last;  assign lst[2] = if2.dout_last;
  assign bsy[0] = if0.busy;       assign bsy[1] = if1.busy;       assign bsy[2] = if2.busy;
  assign dat[0] = if0.dout;       assign dat[1] = if1.dout;       assign dat[2] = if2.dout;

  logic [32:0] exp_q [3][$];
  logic [31:0] idle_exp [3];
  int checks = 0;
  int errors = 0;

  localparam logic [127:0] D1 = 128'h44444444_33333333_22222222_11111111;
  localparam logic [127:0] D3 = 128'hDDDD0004_CCCC0003_BBBB0002_AAAA0001;
  localparam logic [127:0] D5 = 128'h0BAD0004_0BAD0003_0BAD0002_0BAD0001;
  localparam logic [127:0] D6 = 128'h99990004_99990003_99990002_99990001;

  // Monitor: compares every accepted beat against the scoreboard.
  always @(negedge clk) begin
    logic [32:0] e;
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin
        if (vld[i]) begin
          if (rdy[i]) begin
            checks++;
            if (exp_q[i].size() == 0) begin
              errors++;
              $display("FAIL beat_dut%0d: got word %h last %0b, required no beat", i, dat[i], lst[i]);
            end else begin
              e = exp_q[i].pop_front();
              if ({lst[i], dat[i]} !== e) begin
                errors++;
                $display("FAIL beat_dut%0d: got word %h last %0b, required word %h last %0b",
                         i, dat[i], lst[i], e[31:0], e[32]);
              end else begin
                $display("beat dut%0d word %h last %0b", i, dat[i], lst[i]);
              end
            end
          end
        end else begin
          checks++;
          if (dat[i] !== idle_exp[i] || lst[i] !== 1'b0) begin
            errors++;
            $display("FAIL idle_dut%0d: got dout %h last %0b, required dout %h last 0",
                     i, dat[i], lst[i], idle_exp[i]);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end else begin
      $display("check %s = %h", name, got);
    end
  endtask

  task automatic push_burst(input int i, input logic [127:0] d, input int n, input bit msw);
    logic [31:0] w;
    for (int k = 0; k < n; k++) begin
      w = d[(msw ? (n - 1 - k) : k) * 32 +: 32];
      exp_q[i].push_back({(k == n - 1), w});
    end
  endtask

  task automatic wait_idle(input int i);
    for (int k = 0; k < 40 && bsy[i]; k++) tick();
    chk("idle_within_budget", 32'(bsy[i]), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] pat;
    pat = 4'b1001;  // per-cycle ready pattern 1,0,0,1 (bit 0 first)
    for (int i = 0; i < 3; i++) idle_exp[i] = '0;
    rst = 1'b1;
    if0.load = 0; if1.load = 0; if2.load = 0;
    if0.din = '0; if1.din = '0; if2.din = '0;
    if0.dout_ready = 1; if1.dout_ready = 1; if2.dout_ready = 1;
`ifdef PISO_ADDR_READ_EN
    if0.read = 0; if1.read = 0; if2.read = 0;
    if0.addr = '0; if1.addr = '0; if2.addr = '0;
`endif
    repeat (3) tick();
    rst = 1'b0;

    // Reset state
    for (int i = 0; i < 3; i++) begin
      chk("rst_busy", 32'(bsy[i]), 32'd0);
      chk("rst_valid", 32'(vld[i]), 32'd0);
      chk("rst_last", 32'(lst[i]), 32'd0);
      chk("rst_dout", dat[i], 32'd0);
    end

    // Word 0 first, full-rate consumer
    if0.din = D1; if0.load = 1; push_burst(0, D1, 4, 0);
    tick(); if0.load = 0;
    chk("t1_busy_on", 32'(bsy[0]), 32'd1);
    chk("t1_first", dat[0], 32'h11111111);
    repeat (3) tick();
    chk("t1_last_flag", 32'(lst[0]), 32'd1);
    chk("t1_last_word", dat[0], 32'h44444444);
    tick();
    chk("t1_busy_off", 32'(bsy[0]), 32'd0);

    // Word N_REG-1 first
    if1.din = D1; if1.load = 1; push_burst(1, D1, 4, 1);
    tick(); if1.load = 0;
    chk("t2_first", dat[1], 32'h44444444);
    repeat (3) tick();
    chk("t2_last_word", dat[1], 32'h11111111);
    tick();
    chk("t2_busy_off", 32'(bsy[1]), 32'd0);

    // Stalling consumer
    if0.din = D3; if0.load = 1; push_burst(0, D3, 4, 0);
    tick(); if0.load = 0;
    for (int k = 0; k < 40 && bsy[0]; k++) begin
      if0.dout_ready = pat[k % 4];
      tick();
    end
    if0.dout_ready = 1;
    chk("t3_done", 32'(bsy[0]), 32'd0);
    chk("t3_all_beats", 32'(exp_q[0].size()), 32'd0);

    // Load held high through the burst (including final handshake) is ignored
    if0.din = D1; if0.load = 1; push_burst(0, D1, 4, 0);
    tick(); if0.din = D5;
    repeat (4) tick();
    chk("t4_no_recapture_busy", 32'(bsy[0]), 32'd0);
    chk("t4_no_recapture_valid", 32'(vld[0]), 32'd0);
    push_burst(0, D5, 4, 0);
    tick(); if0.load = 0;
    chk("t4_new_burst", dat[0], 32'h0BAD0001);
    wait_idle(0);

    // Reset during beat 2
    if0.din = D6; if0.load = 1; exp_q[0].push_back({1'b0, 32'h99990001});
    tick(); if0.load = 0;
    tick(); rst = 1'b1;
    tick();
    chk("t5_busy", 32'(bsy[0]), 32'd0);
    chk("t5_valid", 32'(vld[0]), 32'd0);
    chk("t5_dout", dat[0], 32'd0);
    chk("t5_last", 32'(lst[0]), 32'd0);
    rst = 1'b0;
    chk("t5_beats", 32'(exp_q[0].size()), 32'd0);
    if0.din = D1; if0.load = 1; push_burst(0, D1, 4, 0);
    tick(); if0.load = 0;
    chk("t5_restart_first", dat[0], 32'h11111111);
    wait_idle(0);

    // Single-word buffer
    if2.din = 32'h5A5A5A5A; if2.load = 1; exp_q[2].push_back({1'b1, 32'h5A5A5A5A});
    tick(); if2.load = 0;
    chk("t6_valid", 32'(vld[2]), 32'd1);
    chk("t6_last", 32'(lst[2]), 32'd1);
    tick();
    chk("t6_busy_off", 32'(bsy[2]), 32'd0);

`ifdef PISO_ADDR_READ_EN
    // Addressed read of word 2 while idle
    if0.read = 1; if0.addr = 2'd2;
    tick(); if0.read = 0; idle_exp[0] = 32'h33333333;
    chk("t7_read_dout", dat[0], 32'h33333333);
    chk("t7_read_valid", 32'(vld[0]), 32'd0);
    tick(); idle_exp[0] = '0;
    chk("t7_read_clear", dat[0], 32'd0);
`endif

    tick();
    for (int i = 0; i < 3; i++) chk("queue_empty", 32'(exp_q[i].size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
